shared_bus_sequencer: RTL and testbench

Downstream consumer of the two-requester `RequestQueue` arbiter. Latches the winning grant, moves a burst of data beats from the granted client onto a single shared bus with a valid/ready handshake, then pulses a per-client done so the client drops its request and the arbiter can re-arbitrate. Sits between the arbiter's `G0`/`G1` outputs and the shared sink.

---
 rtl/shared_bus_sequencer_pkg.sv | 21 ++
 rtl/shared_bus_sequencer_if.sv | 59 +++++
 rtl/shared_bus_sequencer_beat_counter.sv | 32 +++
 rtl/shared_bus_sequencer.sv | 125 ++++++++++++
 tb/tb_shared_bus_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_bus_sequencer_pkg.sv
// Shared definitions for the shared_bus_sequencer block.
// Contents:
//   DW_DEF / LW_DEF : default data width and burst-length field width
//   state_t         : sequencer FSM states (IDLE, XFER, DONE, DRAIN)
//   OWNER_C0/C1     : encoding of bus_owner for client 0 / client 1
package shared_bus_sequencer_pkg;

    localparam int DW_DEF = 8;
    localparam int LW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic OWNER_C0 = 1'b0;
    localparam logic OWNER_C1 = 1'b1;

endpackage

// File: rtl/shared_bus_sequencer_if.sv
// Signal bundle between the arbiter/clients/sink and the sequencer.
// Optional feature: SHARED_BUS_PARITY_EN adds bus_par (XOR of bus_data,
// qualified by bus_valid).
// Modports:
//   master : the sequencer's view (drives the shared bus, client readies,
//            done pulses and status)
//   slave  : the environment's view (arbiter grants, client beats, sink ready)
//
// Handshake: a beat transfers in a cycle where valid and ready are both high
// at the rising edge. Client side: v<n>/rdy<n>; bus side: bus_valid/bus_ready.
// A valid source holds its data until the beat is taken or it withdraws valid;
// ready may be asserted regardless of valid.
interface shared_bus_sequencer_if
    import shared_bus_sequencer_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
);
    logic          G0;
    logic          G1;
    logic [LW-1:0] len0;
    logic [LW-1:0] len1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          v0;
    logic          v1;
    logic          rdy0;
    logic          rdy1;
    logic [DW-1:0] bus_data;
    logic          bus_valid;
    logic          bus_owner;
    logic          bus_ready;
    logic          done0;
    logic          done1;
    logic          busy;
    logic          gnt_err;
`ifdef SHARED_BUS_PARITY_EN
    logic          bus_par;
`endif

    modport master (
        input  G0, G1, len0, len1, d0, d1, v0, v1, bus_ready,
        output rdy0, rdy1, bus_data, bus_valid, bus_owner,
               done0, done1, busy, gnt_err
`ifdef SHARED_BUS_PARITY_EN
        , output bus_par
`endif
    );

    modport slave (
        output G0, G1, len0, len1, d0, d1, v0, v1, bus_ready,
        input  rdy0, rdy1, bus_data, bus_valid, bus_owner,
               done0, done1, busy, gnt_err
`ifdef SHARED_BUS_PARITY_EN
        , input bus_par
`endif
    );

endinterface

// File: rtl/shared_bus_sequencer_beat_counter.sv
// Burst beat counter: holds the remaining beats minus one.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : capture load_val (burst length minus one)
//   load_val     : len of the newly granted client
//   dec          : decrement on an accepted beat that is not the last
//   last         : high when the current beat is the final one (count == 0)
module shared_bus_sequencer_beat_counter #(
    parameter int LW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    input  logic          dec,
    output logic          last
);
    logic [LW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - LW'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/shared_bus_sequencer.sv
// shared_bus_sequencer: latches the arbiter's grant, forwards a burst of
// len+1 beats from the granted client onto the shared bus, pulses that
// client's done for one cycle, then spends one drain cycle so the client can
// drop its request before the next grant is sampled.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   sb           : shared_bus_sequencer_if.master (grants, client beats,
//                  shared bus, done pulses, busy, sticky gnt_err)
//   fsm_state    : current FSM state for observation
// Optional feature: SHARED_BUS_PARITY_EN drives sb.bus_par = ^bus_data while
// bus_valid is high, 0 otherwise.
module shared_bus_sequencer
    import shared_bus_sequencer_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    shared_bus_sequencer_if.master      sb,
    output state_t                      fsm_state
);
    state_t        state_q;
    state_t        state_d;
    logic          owner_q;
    logic          gnt_err_q;

    logic          load;
    logic [LW-1:0] load_val;
    logic          dec;
    logic          last;

    logic          own_v;
    logic [DW-1:0] own_d;
    logic          accept;
    logic          bus_valid_c;
    logic [DW-1:0] bus_data_c;
    logic          rdy0_c;
    logic          rdy1_c;

    shared_bus_sequencer_beat_counter #(.LW(LW)) u_beat_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .last     (last)
    );

    assign own_v = (owner_q == OWNER_C1) ? sb.v1 : sb.v0;
    assign own_d = (owner_q == OWNER_C1) ? sb.d1 : sb.d0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_C0;
            gnt_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // load only fires in IDLE with a grant present; G0 has priority
            if (load) begin
                owner_q <= sb.G0 ? OWNER_C0 : OWNER_C1;
            end
            if (state_q == ST_IDLE && sb.G0 && sb.G1) begin
                gnt_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        load_val    = sb.len0;
        dec         = 1'b0;
        accept      = 1'b0;
        bus_valid_c = 1'b0;
        bus_data_c  = '0;
        rdy0_c      = 1'b0;
        rdy1_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sb.G0) begin
                    load     = 1'b1;
                    load_val = sb.len0;
                    state_d  = ST_XFER;
                end else if (sb.G1) begin
                    load     = 1'b1;
                    load_val = sb.len1;
                    state_d  = ST_XFER;
                end
            end
            ST_XFER: begin
                // zero-latency pass-through between owner and shared bus
                bus_valid_c = own_v;
                bus_data_c  = own_d;
                rdy0_c      = (owner_q == OWNER_C0) && sb.bus_ready;
                rdy1_c      = (owner_q == OWNER_C1) && sb.bus_ready;
                accept      = own_v && sb.bus_ready;
                dec         = accept && !last;
                if (accept && last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign sb.bus_valid = bus_valid_c;
    assign sb.bus_data  = bus_data_c;
    assign sb.rdy0      = rdy0_c;
    assign sb.rdy1      = rdy1_c;
    assign sb.bus_owner = owner_q;
    assign sb.done0     = (state_q == ST_DONE) && (owner_q == OWNER_C0);
    assign sb.done1     = (state_q == ST_DONE) && (owner_q == OWNER_C1);
    assign sb.busy      = (state_q != ST_IDLE);
    assign sb.gnt_err   = gnt_err_q;
`ifdef SHARED_BUS_PARITY_EN
    assign sb.bus_par   = bus_valid_c & (^bus_data_c);
`endif

    assign fsm_state = state_q;

endmodule

// File: tb/tb_shared_bus_sequencer.sv
// Directed bench for shared_bus_sequencer: bus beats and done pulses are
// queued as expectations by the drivers and consumed by a negedge monitor.
module tb_shared_bus_sequencer;
    import shared_bus_sequencer_pkg::*;

    localparam int DW = 8;
    localparam int LW = 4;

    // ---------------- clock / reset ----------------
    logic   clock = 1'b0;
    logic   reset;
    state_t fsm_state;

    always #5 clock = ~clock;

    shared_bus_sequencer_if #(.DW(DW), .LW(LW)) sbi ();

    shared_bus_sequencer #(.DW(DW), .LW(LW)) dut (
        .clock     (clock),
        .reset     (reset),
        .sb        (sbi),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [DW:0] exp_q[$];       // {owner, data}
    logic [1:0]  exp_done_q[$];  // {done1, done0}
    int n_cmp = 0;
    int n_err = 0;
    int ncyc = 0;
    int done_at = -1;
    bit done_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        logic [DW:0] e;
        logic [1:0]  ed;
        if (sbi.bus_valid && sbi.bus_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got 0x%0h with nothing queued", {sbi.bus_owner, sbi.bus_data});
            end else begin
                e = exp_q.pop_front();
                check("bus_beat", 32'({sbi.bus_owner, sbi.bus_data}), 32'(e));
`ifdef SHARED_BUS_PARITY_EN
                check("bus_par", 32'(sbi.bus_par), 32'(^e[DW-1:0]));
`endif
            end
        end
        if (sbi.done0 || sbi.done1) begin
            done_seen = 1'b1;
            done_at   = ncyc;
            if (exp_done_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got 0x%0h with nothing queued", {sbi.done1, sbi.done0});
            end else begin
                ed = exp_done_q.pop_front();
                check("done_pulse", 32'({sbi.done1, sbi.done0}), 32'(ed));
            end
        end
        ncyc++;
    end

    // all-idle output vector: busy,bus_valid,bus_owner,done1,done0,rdy0,rdy1,gnt_err,bus_data
    function automatic logic [31:0] out_vec();
        return 32'({sbi.busy, sbi.bus_valid, sbi.bus_owner, sbi.done1, sbi.done0,
                    sbi.rdy0, sbi.rdy1, sbi.gnt_err, sbi.bus_data});
    endfunction

    // ---------------- driver ----------------
    // One burst from grant to back-in-IDLE. gap_* inserts gap_n idle cycles
    // (v low if gap_on_v, else bus_ready low) starting at XFER cycle gap_at.
    task automatic run_burst(input bit own, input logic [LW-1:0] len, input logic [DW-1:0] base,
                             input int gap_at, input int gap_n, input bit gap_on_v,
                             input bit flip, input bit both, input int exp_lat);
        int c1;
        int i;
        int k;
        bit acc;
        bit gap;
        logic rdy_own;
        logic rdy_oth;
        logic v_own;
        for (int j = 0; j <= int'(len); j++) exp_q.push_back({own, base + DW'(j)});
        exp_done_q.push_back(own ? 2'b10 : 2'b01);
        done_seen = 1'b0;
        if (own) begin
            sbi.G1 = 1'b1;
            sbi.len1 = len;
        end else begin
            sbi.G0 = 1'b1;
            sbi.len0 = len;
        end
        if (both) begin
            sbi.G0 = 1'b1;
            sbi.G1 = 1'b1;
        end
        @(posedge clock); #1;
        c1 = ncyc;
        sbi.G0 = 1'b0;
        sbi.G1 = 1'b0;
        check("busy_after_grant", 32'(sbi.busy), 32'd1);
        check("owner_latched", 32'(sbi.bus_owner), 32'(own));
        i = 0;
        k = 0;
        while (i <= int'(len) && k < 200) begin
            gap = (gap_n > 0) && (k >= gap_at) && (k < gap_at + gap_n);
            if (own) begin
                sbi.d1 = base + DW'(i);
                sbi.v1 = !(gap && gap_on_v);
            end else begin
                sbi.d0 = base + DW'(i);
                sbi.v0 = !(gap && gap_on_v);
            end
            sbi.bus_ready = !(gap && !gap_on_v);
            if (flip && k == 1) begin
                if (own) sbi.G0 = 1'b1;
                else     sbi.G1 = 1'b1;
            end
            @(negedge clock);
            rdy_own = own ? sbi.rdy1 : sbi.rdy0;
            rdy_oth = own ? sbi.rdy0 : sbi.rdy1;
            v_own   = own ? sbi.v1 : sbi.v0;
            check("rdy_other_low", 32'(rdy_oth), 32'd0);
            acc = v_own && rdy_own;
            @(posedge clock); #1;
            if (acc) i++;
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL burst_timeout: got %0d beats expected %0d", i, int'(len) + 1);
        end
        sbi.G0 = 1'b0;
        sbi.G1 = 1'b0;
        sbi.v0 = 1'b0;
        sbi.v1 = 1'b0;
        sbi.d0 = '0;
        sbi.d1 = '0;
        sbi.bus_ready = 1'b1;
        for (int t = 0; t < 10 && !done_seen; t++) begin
            @(negedge clock); #1;
        end
        check("done_seen", 32'(done_seen), 32'd1);
        check("done_latency", 32'(done_at - c1), 32'(exp_lat));
        @(negedge clock); #1;
        check("drain_busy", 32'(sbi.busy), 32'd1);
        check("drain_done_low", 32'({sbi.done1, sbi.done0}), 32'd0);
        @(negedge clock); #1;
        check("idle_busy", 32'(sbi.busy), 32'd0);
        check("idle_state", 32'(fsm_state), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int i;
        int guard;
        reset = 1'b1;
        sbi.G0 = 1'b0;
        sbi.G1 = 1'b0;
        sbi.len0 = '0;
        sbi.len1 = '0;
        sbi.d0 = '0;
        sbi.d1 = '0;
        sbi.v0 = 1'b0;
        sbi.v1 = 1'b0;
        sbi.bus_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock); #1;
        check("reset_outputs", out_vec(), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
`ifdef SHARED_BUS_PARITY_EN
        check("reset_par", 32'(sbi.bus_par), 32'd0);
`endif

        // 4 beats from client 0, continuous handshake
        run_burst(1'b0, 4'd3, 8'h10, 0, 0, 1'b0, 1'b0, 1'b0, 4);
        // single beat from client 1
        run_burst(1'b1, 4'd0, 8'h3C, 0, 0, 1'b0, 1'b0, 1'b0, 1);
        // 3 beats, sink stalls 3 cycles after the first beat
        run_burst(1'b0, 4'd2, 8'hC0, 1, 3, 1'b0, 1'b0, 1'b0, 6);
        // grant flips to client 1 mid-burst
        run_burst(1'b0, 4'd3, 8'h55, 0, 0, 1'b0, 1'b1, 1'b0, 4);
        check("gnt_err_after_flip", 32'(sbi.gnt_err), 32'd0);
        // both grants in IDLE
        run_burst(1'b0, 4'd1, 8'h77, 0, 0, 1'b0, 1'b0, 1'b1, 2);
        check("gnt_err_set", 32'(sbi.gnt_err), 32'd1);
        run_burst(1'b1, 4'd1, 8'h9A, 0, 0, 1'b0, 1'b0, 1'b0, 2);
        check("gnt_err_sticky", 32'(sbi.gnt_err), 32'd1);

        // reset after beat 2 of a 5-beat burst: no done pulse expected
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'hA6});
        sbi.G0 = 1'b1;
        sbi.len0 = 4'd4;
        @(posedge clock); #1;
        sbi.G0 = 1'b0;
        i = 0;
        guard = 0;
        while (i < 2 && guard < 50) begin
            sbi.d0 = 8'hA5 + DW'(i);
            sbi.v0 = 1'b1;
            @(posedge clock); #1;
            i++;
            guard++;
        end
        reset = 1'b1;
        sbi.v0 = 1'b0;
        sbi.bus_ready = 1'b0;
        @(posedge clock); #1;
        check("midburst_reset_outputs", out_vec(), 32'd0);
        check("midburst_reset_state", 32'(fsm_state), 32'(ST_IDLE));
        reset = 1'b0;
        sbi.bus_ready = 1'b1;
        sbi.d0 = '0;
        repeat (5) @(negedge clock);
        #1;
        check("post_reset_idle", out_vec(), 32'd0);

        // max-length burst from client 1 with a 2-cycle valid gap
        run_burst(1'b1, 4'd15, 8'hF0, 3, 2, 1'b1, 1'b0, 1'b0, 18);

        check("beats_left", 32'(exp_q.size()), 32'd0);
        check("dones_left", 32'(exp_done_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard stop if something wedges the stimulus
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
